// File: rtl/param_load_counter.sv
// Loadable up/down modulo counter with clamped load, wrap pulse and sticky overflow flag.
// Optional saturation mode is enabled by defining PLC_SATURATE_EN (adds input sat_i).
`timescale 1ns/1ps

module param_load_counter #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_VAL = 2**WIDTH - 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_en_i,
    input  logic [WIDTH-1:0] load_i,
    input  logic             cnt_en_i,
    input  logic             up_dn_i,
    input  logic             ovf_clr_i,
`ifdef PLC_SATURATE_EN
    input  logic             sat_i,
`endif
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             wrap_o,
    output logic             ovf_o
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             sat;
    logic             at_bound;

`ifdef PLC_SATURATE_EN
    assign sat = sat_i;
`else
    assign sat = 1'b0;
`endif

    assign at_bound = up_dn_i ? (count_q == MaxVal) : (count_q == '0);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q & ~ovf_clr_i;
        if (load_en_i) begin
            count_d = (load_i > MaxVal) ? MaxVal : load_i;
            ovf_d   = 1'b0;
        end else if (cnt_en_i) begin
            if (at_bound) begin
                // Boundary event: overflow always flagged; saturation holds instead of wrapping.
                ovf_d = 1'b1;
                if (!sat) begin
                    count_d = up_dn_i ? '0 : MaxVal;
                    wrap_d  = 1'b1;
                end
            end else if (up_dn_i) begin
                count_d = count_q + WIDTH'(1);
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = wrap_q;
    assign ovf_o   = ovf_q;
    assign tc_o    = at_bound;

endmodule
